instr_fetch_mem: RTL and testbench

INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

---
 rtl/instr_fetch_mem.sv | 157 +++++++++++++++
 tb/tb_instr_fetch_mem.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory: one outstanding fetch, fixed latency.
// Optional macro IMEM_MISALIGN_TRAP_EN faults misaligned fetches.
module instr_fetch_mem #(
   parameter int          DEPTH    = 64,
   parameter int          LATENCY  = 1,
   parameter logic [31:0] NOP_WORD = 32'h00000013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_instr,
   output logic        rsp_fault,
   input  logic        prog_we,
   input  logic [31:0] prog_addr,
   input  logic [31:0] prog_data,
   output logic [15:0] fetch_cnt
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state, state_n;
   logic [2:0]    lat_cnt, lat_cnt_n;
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] req_idx, prog_idx, idx_q, rd_idx;
   logic          req_oor, req_mis, req_fault;
   logic          prog_oor, fault_q, rd_fault;
   logic [31:0]   data_q;
   logic          data_fault_q;
   logic          accept, enter_resp, rsp_done;
   logic          unused_bits;

   assign req_idx   = req_addr[AW+1:2];
   assign req_oor   = |req_addr[31:AW+2];
   assign prog_idx  = prog_addr[AW+1:2];
   assign prog_oor  = |prog_addr[31:AW+2];
`ifdef IMEM_MISALIGN_TRAP_EN
   assign req_mis   = |req_addr[1:0];
`else
   assign req_mis   = 1'b0;
`endif
   assign req_fault = req_oor | req_mis;

   // Byte-offset bits only matter to the optional misalign trap.
   assign unused_bits = ^{req_addr[1:0], prog_addr[1:0]};

   // With LATENCY=1 the read happens on the accept edge itself.
   assign rd_idx   = (state == IDLE) ? req_idx   : idx_q;
   assign rd_fault = (state == IDLE) ? req_fault : fault_q;

   // State and latency counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         lat_cnt <= 3'd0;
      end else begin
         state   <= state_n;
         lat_cnt <= lat_cnt_n;
      end
   end

   // Next-state logic and handshake strobes.
   always_comb begin
      state_n    = state;
      lat_cnt_n  = lat_cnt;
      accept     = 1'b0;
      enter_resp = 1'b0;
      rsp_done   = 1'b0;
      unique case (state)
         IDLE: begin
            if (req_valid) begin
               accept = 1'b1;
               if (LATENCY == 1) begin
                  state_n    = RESP;
                  enter_resp = 1'b1;
                  lat_cnt_n  = 3'd0;
               end else begin
                  state_n   = WAIT;
                  lat_cnt_n = 3'd1;
               end
            end
         end
         WAIT: begin
            if (lat_cnt >= 3'(LATENCY - 1)) begin
               state_n    = RESP;
               enter_resp = 1'b1;
               lat_cnt_n  = 3'd0;
            end else begin
               lat_cnt_n = lat_cnt + 3'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_n  = IDLE;
               rsp_done = 1'b1;
            end
         end
         default: begin
            state_n   = IDLE;
            lat_cnt_n = 3'd0;
         end
      endcase
   end

   // Capture index and fault status of the accepted request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q   <= '0;
         fault_q <= 1'b0;
      end else if (accept) begin
         idx_q   <= req_idx;
         fault_q <= req_fault;
      end
   end

   // Program-load writes; reset refills the array with NOP_WORD.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= NOP_WORD;
         end
      end else if (prog_we && !prog_oor) begin
         mem[prog_idx] <= prog_data;
      end
   end

   // Read the word on the edge entering RESP (sees pre-edge contents).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q       <= NOP_WORD;
         data_fault_q <= 1'b0;
      end else if (enter_resp) begin
         data_fault_q <= rd_fault;
         data_q       <= rd_fault ? NOP_WORD : mem[rd_idx];
      end
   end

   // Saturating count of completed responses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_cnt <= 16'd0;
      end else if (rsp_done && fetch_cnt != 16'hFFFF) begin
         fetch_cnt <= fetch_cnt + 16'd1;
      end
   end

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign rsp_instr = rsp_valid ? data_q : NOP_WORD;
   assign rsp_fault = rsp_valid & data_fault_q;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Bench for instr_fetch_mem: three instances at LATENCY 1, 3 and 2.
// Honours IMEM_MISALIGN_TRAP_EN when computing expected values.
module tb_instr_fetch_mem;

   localparam logic [31:0] NOP = 32'h00000013;
`ifdef IMEM_MISALIGN_TRAP_EN
   localparam bit MIS = 1'b1;
`else
   localparam bit MIS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] req_addr;
   logic        prog_we;
   logic [31:0] prog_addr, prog_data;

   logic        rv  [3];
   logic        rr  [3];
   logic        rdy [3];
   logic        vld [3];
   logic [31:0] ins [3];
   logic        flt [3];
   logic [15:0] cnt [3];

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] instr;
      logic        fault;
   } vec_t;

   vec_t vt [8];

   always #5 clk = ~clk;

   instr_fetch_mem #(.DEPTH(64), .LATENCY(1)) u1 (
      .clk(clk), .reset(reset),
      .req_valid(rv[0]), .req_ready(rdy[0]), .req_addr(req_addr),
      .rsp_valid(vld[0]), .rsp_ready(rr[0]),
      .rsp_instr(ins[0]), .rsp_fault(flt[0]),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .fetch_cnt(cnt[0]));

   instr_fetch_mem #(.DEPTH(64), .LATENCY(3)) u3 (
      .clk(clk), .reset(reset),
      .req_valid(rv[1]), .req_ready(rdy[1]), .req_addr(req_addr),
      .rsp_valid(vld[1]), .rsp_ready(rr[1]),
      .rsp_instr(ins[1]), .rsp_fault(flt[1]),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .fetch_cnt(cnt[1]));

   instr_fetch_mem #(.DEPTH(64), .LATENCY(2)) u2 (
      .clk(clk), .reset(reset),
      .req_valid(rv[2]), .req_ready(rdy[2]), .req_addr(req_addr),
      .rsp_valid(vld[2]), .rsp_ready(rr[2]),
      .rsp_instr(ins[2]), .rsp_fault(flt[2]),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .fetch_cnt(cnt[2]));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, got, exp);
      end
   endtask

   task automatic prog(input logic [31:0] a, input logic [31:0] d);
      prog_we   = 1'b1;
      prog_addr = a;
      prog_data = d;
      tick();
      prog_we = 1'b0;
   endtask

   // One LATENCY=1 fetch on u1 with rsp_ready held high.
   task automatic fetch1(input string nm, input logic [31:0] a,
                         input logic [31:0] ei, input logic ef);
      req_addr = a;
      rv[0]    = 1'b1;
      tick();
      rv[0] = 1'b0;
      chk({nm, " valid"}, 32'(vld[0]), 32'd1);
      chk({nm, " instr"}, ins[0], ei);
      chk({nm, " fault"}, 32'(flt[0]), 32'(ef));
      tick();
      chk({nm, " idle"}, 32'(vld[0]), 32'd0);
   endtask

   int exp_cnt;

   initial begin
      vt[0] = '{32'h0000_0000, NOP,          1'b0};
      vt[1] = '{32'h0000_0004, 32'h019806B3, 1'b0};
      vt[2] = '{32'h0000_00FC, 32'h12345678, 1'b0};
      vt[3] = '{32'h0000_0100, NOP,          1'b1};
      vt[4] = '{32'h0000_0104, NOP,          1'b1};
      vt[5] = '{32'h8000_0004, NOP,          1'b1};
      vt[6] = '{32'h0000_0006, MIS ? NOP : 32'h019806B3, MIS};
      vt[7] = '{32'h0000_00FF, MIS ? NOP : 32'h12345678, MIS};

      reset     = 1'b1;
      req_addr  = '0;
      prog_we   = 1'b0;
      prog_addr = '0;
      prog_data = '0;
      for (int i = 0; i < 3; i++) begin
         rv[i] = 1'b0;
         rr[i] = 1'b0;
      end
      rr[0] = 1'b1;
      #1;
      chk("rst ready", 32'(rdy[0]), 32'd1);
      chk("rst valid", 32'(vld[1]), 32'd0);
      chk("rst instr", ins[2], NOP);
      chk("rst fault", 32'(flt[0]), 32'd0);
      chk("rst cnt", 32'(cnt[0]), 32'd0);
      tick();
      tick();
      reset = 1'b0;
      tick();

      fetch1("l1 addr0", 32'h0, NOP, 1'b0);
      chk("l1 cnt1", 32'(cnt[0]), 32'd1);

      prog(32'h4, 32'h019806B3);
      prog(32'h8, 32'hAABBCCDD);
      prog(32'hFC, 32'h12345678);
      prog(32'h104, 32'hDEADBEEF);

      exp_cnt = 1;
      for (int i = 0; i < 8; i++) begin
         fetch1($sformatf("vec%0d", i), vt[i].addr, vt[i].instr,
                vt[i].fault);
         exp_cnt++;
         chk($sformatf("vec%0d cnt", i), 32'(cnt[0]), 32'(exp_cnt));
      end

      req_addr = 32'h4;
      rv[1]    = 1'b1;
      chk("l3 ready pre", 32'(rdy[1]), 32'd1);
      tick();
      rv[1] = 1'b0;
      chk("l3 ready busy", 32'(rdy[1]), 32'd0);
      chk("l3 valid c1", 32'(vld[1]), 32'd0);
      chk("l3 instr idle", ins[1], NOP);
      tick();
      chk("l3 valid c2", 32'(vld[1]), 32'd0);
      tick();
      chk("l3 valid c3", 32'(vld[1]), 32'd1);
      chk("l3 instr c3", ins[1], 32'h019806B3);
      req_addr = 32'h100;
      rv[1]    = 1'b1;
      tick();
      chk("l3 hold valid", 32'(vld[1]), 32'd1);
      chk("l3 hold instr", ins[1], 32'h019806B3);
      chk("l3 hold fault", 32'(flt[1]), 32'd0);
      tick();
      rv[1] = 1'b0;
      chk("l3 hold2 instr", ins[1], 32'h019806B3);
      chk("l3 cnt pre", 32'(cnt[1]), 32'd0);
      rr[1] = 1'b1;
      tick();
      rr[1] = 1'b0;
      chk("l3 done valid", 32'(vld[1]), 32'd0);
      chk("l3 cnt", 32'(cnt[1]), 32'd1);
      chk("l3 ready back", 32'(rdy[1]), 32'd1);

      req_addr  = 32'h8;
      rv[0]     = 1'b1;
      prog_we   = 1'b1;
      prog_addr = 32'h8;
      prog_data = 32'h55667788;
      tick();
      rv[0]   = 1'b0;
      prog_we = 1'b0;
      chk("race old", ins[0], 32'hAABBCCDD);
      tick();
      fetch1("race new", 32'h8, 32'h55667788, 1'b0);

      req_addr = 32'h8;
      rv[2]    = 1'b1;
      tick();
      rv[2] = 1'b0;
      chk("l2 wait valid", 32'(vld[2]), 32'd0);
      chk("l2 wait ready", 32'(rdy[2]), 32'd0);
      #2;
      reset = 1'b1;
      #1;
      chk("l2 rst ready", 32'(rdy[2]), 32'd1);
      chk("l2 rst valid", 32'(vld[2]), 32'd0);
      chk("l2 rst cnt", 32'(cnt[0]), 32'd0);
      prog_we   = 1'b1;
      prog_addr = 32'hC;
      prog_data = 32'hCAFEF00D;
      tick();
      prog_we = 1'b0;
      reset   = 1'b0;
      rr[2]   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("l2 no rsp %0d", i), 32'(vld[2]), 32'd0);
      end
      fetch1("cleared 8", 32'h8, NOP, 1'b0);
      fetch1("rst prog ign", 32'hC, NOP, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
